// File: rtl/int_pkg.sv
// int_pkg: shared constants for the 8051 interrupt vector sequencer.
//   - Source index constants (bit positions of the request vector).
//   - Default vector base and stride.
//   - Sequencer state encodings (IDLE / REQ).
package int_pkg;

  localparam int unsigned NumSrc = 5;

  localparam logic [2:0] SRC_IE0 = 3'd0;
  localparam logic [2:0] SRC_TF0 = 3'd1;
  localparam logic [2:0] SRC_IE1 = 3'd2;
  localparam logic [2:0] SRC_TF1 = 3'd3;
  localparam logic [2:0] SRC_SER = 3'd4;

  localparam logic [15:0] VEC_BASE_DEF   = 16'h0003;
  localparam int unsigned VEC_STRIDE_DEF = 8;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StReq  = 1'b1;

  // Vector offset of a source, before truncation to the address width.
  function automatic logic [31:0] vec_offset(input int unsigned stride, input logic [2:0] idx);
    return 32'(stride * 32'(idx));
  endfunction

endpackage

// File: rtl/int_vector_seq_if.sv
// int_vector_seq_if: request/vector bundle between IntControl, the sequencer and the CPU.
//   int_req, ip        : pending requests and IP priority bits
//   instr_boundary,
//   defer, reti_done   : CPU instruction-flow qualifiers
//   ack / req, vector,
//   src_id             : vector handshake towards the CPU
//   clr_flag           : one-cycle TCON flag clear
//   in_service         : active service levels {high, low}
// Modport master is the sequencer side, slave is the CPU/IntControl side.
interface int_vector_seq_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [4:0]        int_req;
  logic [4:0]        ip;
  logic              instr_boundary;
  logic              defer;
  logic              reti_done;
  logic              ack;
  logic              req;
  logic [ADDR_W-1:0] vector;
  logic [2:0]        src_id;
  logic [4:0]        clr_flag;
  logic [1:0]        in_service;

  modport master (
    input  int_req, ip, instr_boundary, defer, reti_done, ack,
    output req, vector, src_id, clr_flag, in_service
  );

  modport slave (
    output int_req, ip, instr_boundary, defer, reti_done, ack,
    input  req, vector, src_id, clr_flag, in_service
  );
endinterface

// File: rtl/int_prio_enc.sv
// int_prio_enc: combinational 5-bit lowest-index-first picker.
//   req_i   : candidate request lines
//   valid_o : any candidate present
//   idx_o   : index of the lowest set bit (0 when none)
module int_prio_enc (
  input  logic [4:0] req_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = 3'd0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = 4; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/int_vector_seq.sv
// int_vector_seq: 8051 interrupt vector sequencer.
// Polls pending requests at instruction boundaries, arbitrates by IP level and
// in-service nesting, presents a vector over a req/ack handshake, pulses the
// hardware clear of the serviced TCON flag and tracks in-service levels until RETI.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : int_vector_seq_if master modport (all request/vector signals)
// Build option: define INT_PRIO_EN for two-level priority with nesting; otherwise
// a single low level, fixed index order, and any active service blocks polling.
module int_vector_seq
  import int_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
  parameter int unsigned       VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  int_vector_seq_if.master      bus
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] vector_q, vector_d;
  logic [2:0]        src_id_q, src_id_d;
  logic              lvl_q, lvl_d;        // 1 = latched source is high level
  logic [4:0]        clr_flag_q, clr_flag_d;
  logic [1:0]        in_service_q, in_service_d;

  logic [4:0] hi_cand, lo_cand;
  logic       hi_valid, lo_valid;
  logic [2:0] hi_idx, lo_idx;
  logic       poll;
  logic       sel_valid;
  logic [2:0] sel_idx;
  logic       sel_hi;
  logic [1:0] is_clr, is_set;

  assign poll = bus.instr_boundary & ~bus.defer & ~bus.reti_done;

`ifdef INT_PRIO_EN
  // High sources may nest over a low service; low sources need no service active.
  assign hi_cand = bus.int_req & bus.ip & {5{~in_service_q[1]}};
  assign lo_cand = bus.int_req & ~bus.ip & {5{in_service_q == 2'b00}};
`else
  logic unused_ip;
  assign unused_ip = ^bus.ip;
  assign hi_cand   = 5'b00000;
  assign lo_cand   = bus.int_req & {5{in_service_q == 2'b00}};
`endif

  int_prio_enc u_enc_hi (
    .req_i   (hi_cand),
    .valid_o (hi_valid),
    .idx_o   (hi_idx)
  );

  int_prio_enc u_enc_lo (
    .req_i   (lo_cand),
    .valid_o (lo_valid),
    .idx_o   (lo_idx)
  );

  assign sel_valid = hi_valid | lo_valid;
  assign sel_idx   = hi_valid ? hi_idx : lo_idx;
  assign sel_hi    = hi_valid;

  always_comb begin
    state_d    = state_q;
    vector_d   = vector_q;
    src_id_d   = src_id_q;
    lvl_d      = lvl_q;
    clr_flag_d = 5'b00000;
    is_clr     = 2'b00;
    is_set     = 2'b00;

    // RETI retires the most recently entered (highest) level.
    if (bus.reti_done) begin
      if (in_service_q[1]) begin
        is_clr = 2'b10;
      end else if (in_service_q[0]) begin
        is_clr = 2'b01;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (poll && sel_valid) begin
          state_d  = StReq;
          src_id_d = sel_idx;
          vector_d = VEC_BASE + ADDR_W'(vec_offset(VEC_STRIDE, sel_idx));
          lvl_d    = sel_hi;
        end
      end
      StReq: begin
        if (bus.ack) begin
          state_d = StIdle;
          is_set  = lvl_q ? 2'b10 : 2'b01;
          // Serial RI/TI is cleared by software, so only sources 0..3 get a pulse.
          for (int i = 0; i < 4; i++) begin
            clr_flag_d[i] = (src_id_q == 3'(i));
          end
        end
      end
      default: state_d = StIdle;
    endcase

    in_service_d = (in_service_q & ~is_clr) | is_set;
`ifndef INT_PRIO_EN
    in_service_d[1] = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vector_q     <= '0;
      src_id_q     <= 3'd0;
      lvl_q        <= 1'b0;
      clr_flag_q   <= 5'b00000;
      in_service_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      vector_q     <= vector_d;
      src_id_q     <= src_id_d;
      lvl_q        <= lvl_d;
      clr_flag_q   <= clr_flag_d;
      in_service_q <= in_service_d;
    end
  end

  assign bus.req        = (state_q == StReq);
  assign bus.vector     = vector_q;
  assign bus.src_id     = src_id_q;
  assign bus.clr_flag   = clr_flag_q;
  assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_int_vector_seq.sv
module tb_int_vector_seq;

  typedef struct packed {
    logic [2:0]  src;
    logic [15:0] vec;
  } exp_req_t;

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  exp_req_t   req_q[$];
  logic [4:0] clr_q[$];

  int_vector_seq_if #(.ADDR_W(16)) bus ();

  int_vector_seq #(.ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected vectors on each new request and expected clears after each ack.
  logic req_prev;
  logic ack_seen;
  always @(negedge clk) begin
    if (!rst_n) begin
      req_prev = 1'b0;
      ack_seen = 1'b0;
    end else begin
      if (ack_seen) begin
        if (clr_q.size() == 0) begin
          chk("clr_queue_empty", 32'd1, 32'd0);
        end else begin
          chk("clr_flag", 32'(bus.clr_flag), 32'(clr_q.pop_front()));
        end
        chk("req_drop_after_ack", 32'(bus.req), 32'd0);
      end else if (bus.clr_flag != 5'b00000) begin
        chk("clr_flag_spurious", 32'(bus.clr_flag), 32'd0);
      end
      if (bus.req && !req_prev) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 32'(bus.src_id), 32'hFFFF);
        end else begin
          exp_req_t e;
          e = req_q.pop_front();
          chk("src_id", 32'(bus.src_id), 32'(e.src));
          chk("vector", 32'(bus.vector), 32'(e.vec));
        end
      end
      ack_seen = bus.req && bus.ack;
      req_prev = bus.req;
    end
  end

  task automatic poll(input logic [4:0] rq, input logic [4:0] ipv, input logic dfr);
    bus.int_req        = rq;
    bus.ip             = ipv;
    bus.defer          = dfr;
    bus.instr_boundary = 1'b1;
    @(posedge clk); #1;
    bus.instr_boundary = 1'b0;
    bus.defer          = 1'b0;
  endtask

  task automatic expect_req(input logic [2:0] src, input logic [15:0] vec);
    exp_req_t e;
    e.src = src;
    e.vec = vec;
    req_q.push_back(e);
  endtask

  task automatic do_ack(input logic reti, input logic [4:0] exp_clr);
    int n;
    n = 0;
    while (!bus.req && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req) begin
      chk("req_timeout", 32'd0, 32'd1);
    end else begin
      clr_q.push_back(exp_clr);
      bus.ack       = 1'b1;
      bus.reti_done = reti;
      @(posedge clk); #1;
      bus.ack       = 1'b0;
      bus.reti_done = 1'b0;
    end
  endtask

  task automatic check_no_req(input string name);
    @(negedge clk);
    chk(name, 32'(bus.req), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_is(input string name, input logic [1:0] exp);
    @(negedge clk);
    chk(name, 32'(bus.in_service), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic reti();
    bus.reti_done = 1'b1;
    @(posedge clk); #1;
    bus.reti_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n              = 1'b0;
    bus.int_req        = 5'b11111;
    bus.ip             = 5'b00000;
    bus.instr_boundary = 1'b1;
    bus.defer          = 1'b0;
    bus.reti_done      = 1'b0;
    bus.ack            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.req), 32'd0);
    chk("rst_vector", 32'(bus.vector), 32'd0);
    chk("rst_src_id", 32'(bus.src_id), 32'd0);
    chk("rst_clr_flag", 32'(bus.clr_flag), 32'd0);
    chk("rst_in_service", 32'(bus.in_service), 32'd0);
    bus.instr_boundary = 1'b0;
    bus.int_req        = 5'b00000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic service of IE0.
    expect_req(3'd0, 16'h0003);
    poll(5'b00101, 5'b00000, 1'b0);
    do_ack(1'b0, 5'b00001);
    check_is("is_after_ie0", 2'b01);

`ifdef INT_PRIO_EN
    // High-level TF1 nests over the low service.
    expect_req(3'd3, 16'h001B);
    poll(5'b01010, 5'b01000, 1'b0);
    do_ack(1'b0, 5'b01000);
    check_is("is_nested", 2'b11);
    poll(5'b11111, 5'b11111, 1'b0);
    check_no_req("no_req_high_busy");
    reti();
    check_is("is_after_reti_hi", 2'b01);
`else
    poll(5'b01000, 5'b01000, 1'b0);
    check_no_req("no_req_busy_noprio");
`endif

    // Same-level request is blocked until RETI.
    poll(5'b00010, 5'b00000, 1'b0);
    check_no_req("no_req_same_level");
    reti();
    check_is("is_after_reti_lo", 2'b00);
    expect_req(3'd1, 16'h000B);
    poll(5'b00010, 5'b00000, 1'b0);
    do_ack(1'b0, 5'b00010);
    reti();
    check_is("is_after_tf0", 2'b00);

    // Deferred boundary, then serial source with no flag clear.
    poll(5'b10000, 5'b00000, 1'b1);
    check_no_req("no_req_defer");
    expect_req(3'd4, 16'h0023);
    poll(5'b10000, 5'b00000, 1'b0);
    do_ack(1'b0, 5'b00000);
    check_is("is_after_ser", 2'b01);
    reti();

    // Latched vector holds while int_req drops and boundaries keep coming.
    expect_req(3'd2, 16'h0013);
    poll(5'b00100, 5'b00000, 1'b0);
    bus.int_req        = 5'b00001;
    bus.instr_boundary = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.instr_boundary = 1'b0;
    bus.int_req        = 5'b00000;
    @(negedge clk);
    chk("hold_req", 32'(bus.req), 32'd1);
    chk("hold_vector", 32'(bus.vector), 32'h0013);
    chk("hold_src_id", 32'(bus.src_id), 32'd2);
    @(posedge clk); #1;
    // RETI with nothing in service alongside ack: only the set applies.
    do_ack(1'b1, 5'b00100);
    check_is("is_ack_reti_idle", 2'b01);
    reti();

`ifdef INT_PRIO_EN
    // ack+reti together during a nested high service.
    expect_req(3'd0, 16'h0003);
    poll(5'b00001, 5'b00000, 1'b0);
    do_ack(1'b0, 5'b00001);
    expect_req(3'd1, 16'h000B);
    poll(5'b00010, 5'b00010, 1'b0);
    do_ack(1'b1, 5'b00010);
    check_is("is_ack_reti_nested", 2'b10);
    reti();
    // High group beats a lower index in the low group.
    expect_req(3'd1, 16'h000B);
    poll(5'b00011, 5'b00010, 1'b0);
    do_ack(1'b0, 5'b00010);
    check_is("is_high_pick", 2'b10);
    reti();
`else
    expect_req(3'd0, 16'h0003);
    poll(5'b00011, 5'b00010, 1'b0);
    do_ack(1'b0, 5'b00001);
    check_is("is_fixed_pick", 2'b01);
    reti();
`endif
    check_is("is_clear_again", 2'b00);

    // ack in IDLE does nothing.
    bus.ack = 1'b1;
    @(posedge clk); #1;
    bus.ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_req", 32'(bus.req), 32'd0);
    chk("idle_ack_is", 32'(bus.in_service), 32'd0);
    @(posedge clk); #1;

    // Reset mid-REQ drops req without a clock edge.
    expect_req(3'd0, 16'h0003);
    poll(5'b00001, 5'b00000, 1'b0);
    bus.int_req = 5'b00000;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus.req), 32'd0);
    chk("async_rst_vector", 32'(bus.vector), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("req_queue_drained", 32'(req_q.size()), 32'd0);
    chk("clr_queue_drained", 32'(clr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
